seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Multi-cycle unsigned shift-add multiplier for the lab datapath. It accepts two N-bit operands under a start/busy/done handshake and produces a 2N-bit product. The product feeds directly into the downstream N-bit pipeline registers: the low and high halves each go to an NBit_Register-style bank, sampled when done is high. It is built from flip-flops plus one N-bit adder, with no combinational multiplier array.

Parameters:
N, 32, operand width in bits; product is 2N bits
CW, $clog2(N)+1, iteration counter width

Ports:
clk  input  1  rising-edge clock, shared with downstream registers
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  N  multiplicand, captured on accepting edge
b  input  N  multiplier, captured on accepting edge
busy  output  1  high while an operation is in progress (state RUN)
done  output  1  one-cycle pulse; product valid
product  output  2N  result; held stable until the next start is accepted

Behaviour:
- Reset (rst_n=0, asynchronous), all outputs and state cleared:
  - state=IDLE, busy=0, done=0, product=0
  - internal acc, multiplier copy, multiplicand copy and counter = 0
- Reset release is synchronous to clk: the first active edge is the one after rst_n rises.
- Three states:
  - IDLE, RUN, DONE, encoded IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - The unused code 2'b11 goes to IDLE on the next edge.
- IDLE:
  - start=1 at edge E0: capture mcand<=a, mplr<=b, acc<=0, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: one iteration per edge, edges E1..EN.
  - sum = {1'b0,acc_hi} + (mplr[0] ? {1'b0,mcand} : 0), an (N+1)-bit sum.
  - Shift {sum, acc_lo/mplr} right by 1. The combined 2N-bit shift register holds acc_hi in the upper half and mplr in the lower half.
  - cnt increments each edge.
  - When cnt==N-1 at an edge, that edge is the last iteration. State goes to DONE, and product is loaded from the final shift result on the same edge.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - start=1: accepted exactly as from IDLE, so back-to-back operation costs no idle cycle.
  - start=0: go to IDLE.
- Timing:
  - busy=1 in the cycles following E0 through EN.
  - done=1 in the cycle following EN.
  - Latency: done appears N+1 edges after start is sampled, counting E0.
- start while busy=1 is ignored; there is no queueing and no error flag.
- a and b may change freely after E0, with no effect on the operation in flight.
- product:
  - updates only at the final RUN edge and keeps its value through DONE and IDLE.
  - a new start does not clear it; it is overwritten only at the next completion.
- Arithmetic:
  - unsigned, and the result is exact for all inputs: 2N bits never overflow.
  - the carry bit of the (N+1)-bit sum must be kept.
- Reset asserted mid-RUN aborts the operation: product=0, and no done pulse is produced.
- done and busy are never both 1.

Decomposition:
- Shared package mult_pkg:
  - state encoding localparams IDLE/RUN/DONE
  - the state typedef (2-bit)
  - default N=32
- Natural sub-module: shift_add_datapath, containing acc/mplr shift register, mcand register, adder and counter. Control inputs: load, step. Status output: last.
- The top module holds the FSM and the product register.

Test Plan:
- Reset then start with a=3, b=5 -> busy for 32 cycles; done pulses once in the 33rd cycle after E0; product=64'h0000_0000_0000_000F.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 (exercises the adder carry).
- a=0, b=32'h1234_5678, then a=32'h8000_0000, b=2 -> product 0 then 64'h0000_0001_0000_0000; product holds 0 until the second done.
- Pulse start again with a=7, b=7 at the 10th RUN cycle of a 6*9 operation -> ignored; product=54; only one done pulse.
- start held high continuously with a=2, b=3 -> done every 33 cycles, no IDLE cycle between operations; product=6 each time.
- Assert rst_n=0 asynchronously mid-edge during RUN (a=100, b=100) -> busy, done and product drop to 0 immediately; no done pulse after release; a following start 4*4 gives product=16.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: state encoding and default width shared by the sequential multiplier.
package mult_pkg;
    localparam int N_DEFAULT = 32;
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/busy/done handshake, operands and product of the multiplier.
interface seq_multiplier_if import mult_pkg::*; #(parameter int N = N_DEFAULT);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    modport master (output start, a, b, input busy, done, product);
    modport slave (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_datapath.sv
// shift_add_datapath: acc/multiplier shift register, multiplicand register, one adder and counter.
module shift_add_datapath import mult_pkg::*; #(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic           i_step,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_last,
    output logic [2*N-1:0] o_result
);
    logic [N-1:0]   r_acc;
    logic [N-1:0]   r_mplr;
    logic [N-1:0]   r_mcand;
    logic [CW-1:0]  r_cnt;
    logic [N:0]     w_sum;
    logic [2*N-1:0] w_shift;
    // The adder carry becomes the top bit of the shifted accumulator.
    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : '0);
        w_shift = {w_sum, r_mplr[N-1:1]};
    end
    assign o_last   = r_cnt == CW'(N - 1);
    assign o_result = w_shift;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mplr  <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_mplr  <= i_b;
            r_mcand <= i_a;
            r_cnt   <= '0;
        end else if (i_step) begin
            r_acc   <= w_shift[2*N-1:N];
            r_mplr  <= w_shift[N-1:0];
            r_cnt   <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle unsigned shift-add multiplier with start/busy/done handshake.
module seq_multiplier import mult_pkg::*; #(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_multiplier_if.slave bus
);
    state_t         r_state;
    state_t         w_next;
    logic           w_load;
    logic           w_step;
    logic           w_last;
    logic [2*N-1:0] w_result;
    logic [2*N-1:0] r_product;
    shift_add_datapath #(.N(N), .CW(CW)) u_dp (
        .clk(clk),
        .rst_n(rst_n),
        .i_load(w_load),
        .i_step(w_step),
        .i_a(bus.a),
        .i_b(bus.b),
        .o_last(w_last),
        .o_result(w_result)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    // DONE accepts start like IDLE so back-to-back operations lose no cycle.
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_next = IDLE;
        case (r_state)
            IDLE, DONE: begin
                w_load = bus.start;
                w_next = bus.start ? RUN : IDLE;
            end
            RUN: begin
                w_step = 1'b1;
                w_next = w_last ? DONE : RUN;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_product <= '0;
        else if (w_step && w_last) r_product <= w_result;
    end
    assign bus.busy    = r_state == RUN;
    assign bus.done    = r_state == DONE;
    assign bus.product = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random operations checked every cycle against a cycle-count model.
module tb_seq_multiplier;
    import mult_pkg::*;
    localparam int N = 32;
    localparam int W = 2 * N;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_err = 0;
    seq_multiplier_if #(.N(N)) bus ();
    seq_multiplier #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // Model: an accepted start is busy for N cycles, then done for one with product = a*b.
    int m_left = 0;
    logic m_done = 1'b0;
    logic [W-1:0] m_prod = '0;
    logic [W-1:0] m_pend = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_pend <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= m_left == 1;
            if (m_left == 1) m_prod <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_left <= N;
                m_pend <= W'(bus.a) * W'(bus.b);
            end
        end
    end
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        check("cyc_busy", W'(bus.busy), W'(m_left > 0));
        check("cyc_done", W'(bus.done), W'(m_done));
        check("cyc_product", bus.product, m_prod);
        check("cyc_excl", W'(bus.busy & bus.done), '0);
    end
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic [W-1:0] prev,
                          output int bc);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bc = 0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bc++;
            if (lat == N / 2) check("op_hold", bus.product, prev);
            @(negedge clk);
            lat++;
        end
        check("op_latency", W'(lat), W'(N + 1));
        check("op_product", bus.product, W'(x) * W'(y));
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int bc, dones, last;
        logic [N-1:0] x, y;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_done", W'(bus.done), '0);
        check("rst_product", bus.product, '0);
        rst_n = 1'b1;
        run_op(32'd3, 32'd5, '0, bc);
        check("t1_busy_cycles", W'(bc), W'(32));
        check("t1_product", bus.product, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hF, bc);
        check("t2_product", bus.product, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h0, 32'h1234_5678, 64'hFFFF_FFFE_0000_0001, bc);
        check("t3a_product", bus.product, 64'h0);
        run_op(32'h8000_0000, 32'd2, 64'h0, bc);
        check("t3b_product", bus.product, 64'h0000_0001_0000_0000);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd6;
        bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd7;
        bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("t4_dones", W'(dones), W'(1));
        check("t4_product", bus.product, 64'd54);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd2;
        bus.b = 32'd3;
        dones = 0;
        last = 0;
        for (int i = 1; i <= 99; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                last = i;
                check("t5_product", bus.product, 64'd6);
            end
        end
        bus.start = 1'b0;
        check("t5_dones", W'(dones), W'(3));
        check("t5_last_done", W'(last), W'(99));
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd100;
        bus.b = 32'd100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", W'(bus.busy), '0);
        check("t6_done", W'(bus.done), '0);
        check("t6_product", bus.product, '0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("t6_no_done", W'(dones), '0);
        run_op(32'd4, 32'd4, '0, bc);
        check("t6_product16", bus.product, 64'd16);
        for (int k = 0; k < 30; k++) begin
            x = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
            y = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(x, y, m_prod, bc);
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
